// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mem_pkg
//  Desc     : Shared constants and loader state encoding for the banked
//             instruction memory of the summer_cpu core.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_mem_pkg;

    // Word returned on a bad fetch: decodes as "jr $zero"
    localparam logic [31:0] c_DEFAULT_WORD = 32'h0000_0008;

    // Base of the kernel/handler bank; only bit 31 distinguishes the banks
    localparam logic [31:0] c_KERN_BASE    = 32'h8000_0000;

    // Byte-serial loader states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } ld_state_t;

endpackage : cpu_mem_pkg
`default_nettype wire

// File: rtl/mem_bank.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bank
//  Desc     : 32-bit synchronous RAM with one write port and one read port.
//             Read data is registered and only updates when i_re is high, so
//             the last fetched word stays on o_rdata. Read-first on collision.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bank
    import cpu_mem_pkg::*;
#(
    parameter int    DEPTH = 64,
    parameter string INIT  = ""
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [31:0]              i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [31:0]              o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Write and registered read share one edge; the read sees the old word
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : mem_bank
`default_nettype wire

// File: rtl/inst_mem_banked.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem_banked
//  Desc     : Two-bank (user / kernel) loadable instruction memory with a
//             registered, stallable fetch port and a byte-serial loader.
//  Revision : 1.0  initial release
// ============================================================================
module inst_mem_banked
    import cpu_mem_pkg::*;
#(
    parameter int          DEPTH_USER   = 64,
    parameter int          DEPTH_KERN   = 128,
    parameter logic [31:0] DEFAULT_WORD = c_DEFAULT_WORD,
    parameter string       INIT_USER    = "",
    parameter string       INIT_KERN    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic        rd_stall,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_err,
    input  logic        ld_start,
    input  logic        ld_bank,
    input  logic [15:0] ld_len,
    input  logic        ld_byte_vld,
    input  logic [7:0]  ld_byte,
    output logic        ld_busy,
    output logic        ld_done
);

    localparam int          IW_U    = $clog2(DEPTH_USER);
    localparam int          IW_K    = $clog2(DEPTH_KERN);
    localparam logic [15:0] c_LEN_U = 16'(DEPTH_USER);
    localparam logic [15:0] c_LEN_K = 16'(DEPTH_KERN);

    // ------------------------------------------------------------------
    // Fetch address decode
    // ------------------------------------------------------------------
    logic        w_kern;
    logic [31:0] w_off;
    logic        w_hi_u;
    logic        w_hi_k;
    logic        w_err;
    logic        w_acc;
    logic        w_re_u;
    logic        w_re_k;
    logic [31:0] w_q_u;
    logic [31:0] w_q_k;

    assign w_kern = |(rd_addr & c_KERN_BASE);
    assign w_off  = rd_addr & ~c_KERN_BASE;
    assign w_hi_u = |(w_off >> (IW_U + 2));
    assign w_hi_k = |(w_off >> (IW_K + 2));
    assign w_err  = (|rd_addr[1:0]) || (w_kern ? w_hi_k : w_hi_u);
    assign w_acc  = rd_req && !rd_stall;
    assign w_re_u = w_acc && !w_kern && !w_err;
    assign w_re_k = w_acc &&  w_kern && !w_err;

    // ------------------------------------------------------------------
    // Output / stall register. r_dflt forces DEFAULT_WORD both after reset
    // and after a bad fetch, while rd_err only reports the latter.
    // ------------------------------------------------------------------
    logic r_valid;
    logic r_err;
    logic r_dflt;
    logic r_sel;

    // Capture fetch status on every accepted request, hold under stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_dflt  <= 1'b1;
            r_sel   <= 1'b0;
        end else if (!rd_stall) begin
            r_valid <= rd_req;
            if (rd_req) begin
                r_err  <= w_err;
                r_dflt <= w_err;
                r_sel  <= w_kern;
            end
        end
    end

    assign rd_valid = r_valid;
    assign rd_err   = r_err;
    assign rd_data  = r_dflt ? DEFAULT_WORD : (r_sel ? w_q_k : w_q_u);

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    ld_state_t   r_state;
    ld_state_t   w_next;
    logic        r_bank;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [31:0] r_word;
    logic [1:0]  r_bcnt;
    logic [15:0] w_idx_inc;
    logic [15:0] w_len_clamp;
    logic        w_we_u;
    logic        w_we_k;

    assign w_idx_inc   = r_idx + 16'd1;
    assign w_len_clamp = ld_bank ? ((ld_len > c_LEN_K) ? c_LEN_K : ld_len)
                                 : ((ld_len > c_LEN_U) ? c_LEN_U : ld_len);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (ld_start) w_next = (ld_len != 16'd0) ? S_LOAD : S_DONE;
            S_LOAD:  if (ld_byte_vld && (r_bcnt == 2'd3)) w_next = S_WRITE;
            S_WRITE: w_next = (w_idx_inc == r_len) ? S_DONE : S_LOAD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Loader datapath: length/bank capture, byte assembly, word index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bank <= 1'b0;
            r_len  <= 16'd0;
            r_idx  <= 16'd0;
            r_word <= 32'd0;
            r_bcnt <= 2'd0;
        end else begin
            if ((r_state == S_IDLE) && ld_start) begin
                r_bank <= ld_bank;
                r_len  <= w_len_clamp;
                r_idx  <= 16'd0;
                r_bcnt <= 2'd0;
            end
            if ((r_state == S_LOAD) && ld_byte_vld) begin
                r_word <= {r_word[23:0], ld_byte};
                r_bcnt <= r_bcnt + 2'd1;
            end
            if (r_state == S_WRITE) begin
                r_idx <= w_idx_inc;
            end
        end
    end

    assign w_we_u  = (r_state == S_WRITE) && !r_bank;
    assign w_we_k  = (r_state == S_WRITE) &&  r_bank;
    assign ld_busy = (r_state != S_IDLE);
    assign ld_done = (r_state == S_DONE);

    // ------------------------------------------------------------------
    // Banks
    // ------------------------------------------------------------------
    mem_bank #(
        .DEPTH (DEPTH_USER),
        .INIT  (INIT_USER)
    ) u_bank_user (
        .clk     (clk),
        .i_we    (w_we_u),
        .i_waddr (r_idx[IW_U-1:0]),
        .i_wdata (r_word),
        .i_re    (w_re_u),
        .i_raddr (rd_addr[IW_U+1:2]),
        .o_rdata (w_q_u)
    );

    mem_bank #(
        .DEPTH (DEPTH_KERN),
        .INIT  (INIT_KERN)
    ) u_bank_kern (
        .clk     (clk),
        .i_we    (w_we_k),
        .i_waddr (r_idx[IW_K-1:0]),
        .i_wdata (r_word),
        .i_re    (w_re_k),
        .i_raddr (rd_addr[IW_K+1:2]),
        .o_rdata (w_q_k)
    );

endmodule : inst_mem_banked
`default_nettype wire

// File: tb/tb_inst_mem_banked.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_mem_banked
//  Desc     : Self-checking bench for inst_mem_banked: loader sequences,
//             a fetch vector table and randomized fetch traffic checked
//             against an array-based memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_mem_banked;

    localparam int DU = 64;
    localparam int DK = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_stall;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        ld_start;
    logic        ld_bank;
    logic [15:0] ld_len;
    logic        ld_byte_vld;
    logic [7:0]  ld_byte;
    logic        ld_busy;
    logic        ld_done;

    inst_mem_banked dut (
        .clk         (clk),
        .reset       (reset),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_stall    (rd_stall),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_err      (rd_err),
        .ld_start    (ld_start),
        .ld_bank     (ld_bank),
        .ld_len      (ld_len),
        .ld_byte_vld (ld_byte_vld),
        .ld_byte     (ld_byte),
        .ld_busy     (ld_busy),
        .ld_done     (ld_done)
    );

    always #5 clk = ~clk;

    // Reference memory contents and outstanding expected outputs
    logic [31:0] m_u [DU];
    logic [31:0] m_k [DK];
    logic [31:0] ld_q [256];
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic        err;
        logic [31:0] data;
    } vec_t;
    vec_t tbl [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected fetch result straight from the address map rules
    task automatic model_fetch(input logic [31:0] a, output logic err, output logic [31:0] d);
        logic        kern;
        longint      off;
        longint      depth;
        kern  = (a >= 32'h8000_0000);
        off   = kern ? longint'(a) - 64'h8000_0000 : longint'(a);
        depth = kern ? DK : DU;
        if ((off % 4) != 0 || off >= depth * 4) begin
            err = 1'b1;
            d   = 32'h0000_0008;
        end else begin
            err = 1'b0;
            d   = kern ? m_k[int'(off / 4)] : m_u[int'(off / 4)];
        end
    endtask

    // Drive one load: start, nsend words of ld_q as bytes, wait for done
    task automatic ld_run(input logic bank, input int len, input int nsend,
                          input bit poke_start, input bit probe);
        logic [31:0] old0;
        int          nwr;
        int          depth;
        old0 = bank ? m_k[0] : m_u[0];
        ld_start = 1'b1; ld_bank = bank; ld_len = len[15:0];
        step();
        ld_start = 1'b0;
        chk("ld_busy_start", 32'(ld_busy), 32'd1);
        for (int w = 0; w < nsend; w++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ld_byte_vld = 1'b0;
                    step();
                end
                ld_byte_vld = 1'b1;
                ld_byte     = ld_q[w][31-8*b -: 8];
                if (poke_start && w == 0 && b == 2) begin
                    ld_start = 1'b1; ld_bank = !bank; ld_len = 16'd0;
                end
                step();
                ld_start = 1'b0;
            end
            ld_byte_vld = 1'b0;
            if (probe && w == 0) begin
                rd_req = 1'b1; rd_addr = bank ? 32'h8000_0000 : 32'h0;
                step();
                rd_req = 1'b0;
                chk("read_first", rd_data, old0);
            end else begin
                step();
            end
        end
        for (int t = 0; t < 8 && ld_done !== 1'b1; t++) step();
        chk("ld_done_pulse", 32'(ld_done), 32'd1);
        step();
        chk("ld_done_clear", 32'({ld_busy, ld_done}), 32'd0);
        depth = bank ? DK : DU;
        nwr = len;
        if (nwr > depth) nwr = depth;
        if (nwr > nsend) nwr = nsend;
        for (int i = 0; i < nwr; i++) begin
            if (bank) m_k[i] = ld_q[i];
            else      m_u[i] = ld_q[i];
        end
    endtask

    // Single fetch checked against the model
    task automatic fetch_chk(input string nm, input logic [31:0] a);
        logic        e;
        logic [31:0] d;
        model_fetch(a, e, d);
        rd_req = 1'b1; rd_addr = a; rd_stall = 1'b0;
        step();
        rd_req = 1'b0;
        chk({nm, "_data"}, rd_data, d);
        chk({nm, "_err"}, 32'(rd_err), 32'(e));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        e_valid;
        logic        e_err;
        logic [31:0] e_data;
        logic        kb;
        int          idx;
        logic [31:0] a;
        bit          busy_seen;

        reset = 1'b1; rd_req = 1'b0; rd_addr = 32'h0; rd_stall = 1'b0;
        ld_start = 1'b0; ld_bank = 1'b0; ld_len = 16'd0;
        ld_byte_vld = 1'b0; ld_byte = 8'h00;
        step(); step();
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data",  rd_data, 32'h0000_0008);
        chk("rst_err",   32'(rd_err), 32'd0);
        chk("rst_busy",  32'(ld_busy), 32'd0);
        chk("rst_done",  32'(ld_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Preload user bank with an over-long length (clamped to 64 words)
        for (int i = 0; i < DU; i++) ld_q[i] = 32'h1000_0000 + 32'(i) * 32'h101;
        ld_run(1'b0, 100, DU, 1'b0, 1'b0);
        // Surplus bytes after completion must be dropped
        busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ld_byte_vld = 1'b1; ld_byte = 8'($urandom);
            step();
            if (ld_busy) busy_seen = 1'b1;
        end
        ld_byte_vld = 1'b0;
        chk("surplus_busy", 32'(busy_seen), 32'd0);

        // Preload kernel bank; a second ld_start mid-load must be ignored
        for (int i = 0; i < DK; i++) ld_q[i] = 32'h8800_0000 + 32'(i);
        ld_run(1'b1, DK, DK, 1'b1, 1'b0);

        // Two-word program into user bank, read-first probe on word 0
        ld_q[0] = 32'h3C15_4000;
        ld_q[1] = 32'h2009_0000;
        ld_run(1'b0, 2, 2, 1'b0, 1'b1);

        // Fetch vector table, applied back to back
        tbl[0] = '{32'h0000_0000, 1'b0, 32'h3C15_4000};
        tbl[1] = '{32'h0000_0004, 1'b0, 32'h2009_0000};
        tbl[2] = '{32'h0000_0008, 1'b0, 32'h1000_0202};
        tbl[3] = '{32'h0000_00FC, 1'b0, 32'h1000_3F3F};
        tbl[4] = '{32'h8000_00CC, 1'b0, 32'h8800_0033};
        tbl[5] = '{32'h8000_01FC, 1'b0, 32'h8800_007F};
        tbl[6] = '{32'h0000_0102, 1'b1, 32'h0000_0008};
        tbl[7] = '{32'h8000_0200, 1'b1, 32'h0000_0008};
        tbl[8] = '{32'h8000_0001, 1'b1, 32'h0000_0008};
        tbl[9] = '{32'h0000_1000, 1'b1, 32'h0000_0008};
        for (int i = 0; i < 10; i++) begin
            rd_req = 1'b1; rd_addr = tbl[i].addr;
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'd1);
            chk($sformatf("tbl%0d_err", i),   32'(rd_err), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_data", i),  rd_data, tbl[i].data);
        end

        // Stall for 3 cycles with a different request pending: outputs hold
        rd_stall = 1'b1; rd_addr = 32'h0000_0004;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(rd_valid), 32'd1);
            chk("stall_err",   32'(rd_err), 32'd1);
            chk("stall_data",  rd_data, 32'h0000_0008);
        end
        // Release with no request: valid drops, data holds
        rd_stall = 1'b0; rd_req = 1'b0;
        step();
        chk("idle_valid", 32'(rd_valid), 32'd0);
        chk("idle_data",  rd_data, 32'h0000_0008);

        // Zero-length load: done next cycle, nothing written
        ld_run(1'b1, 0, 0, 1'b0, 1'b0);
        fetch_chk("len0_k0", 32'h8000_0000);

        // Reset after two bytes of word 1 in a 2-word load
        ld_start = 1'b1; ld_bank = 1'b0; ld_len = 16'd2;
        step();
        ld_start = 1'b0;
        ld_q[0] = 32'hAAAA_5555;
        for (int b = 0; b < 4; b++) begin
            ld_byte_vld = 1'b1; ld_byte = ld_q[0][31-8*b -: 8];
            step();
        end
        ld_byte_vld = 1'b0;
        step();
        ld_byte_vld = 1'b1; ld_byte = 8'hDE; step();
        ld_byte_vld = 1'b1; ld_byte = 8'hAD; step();
        ld_byte_vld = 1'b0;
        reset = 1'b1;
        #2;
        chk("midrst_busy",  32'(ld_busy), 32'd0);
        chk("midrst_valid", 32'(rd_valid), 32'd0);
        chk("midrst_data",  rd_data, 32'h0000_0008);
        @(negedge clk);
        reset = 1'b0;
        step();
        m_u[0] = 32'hAAAA_5555;
        fetch_chk("midrst_w0", 32'h0000_0000);
        fetch_chk("midrst_w1", 32'h0000_0004);
        // Partial word must not leak into the next load
        ld_q[0] = 32'h0BAD_F00D;
        ld_run(1'b0, 1, 1, 1'b0, 1'b0);
        fetch_chk("postrst_w0", 32'h0000_0000);

        // Randomized fetch traffic with stalls against the model
        rd_req = 1'b1; rd_addr = 32'h0000_0004; rd_stall = 1'b0;
        e_valid = 1'b1;
        model_fetch(rd_addr, e_err, e_data);
        step();
        for (int c = 0; c < 400; c++) begin
            chk("rnd_valid", 32'(rd_valid), 32'(e_valid));
            chk("rnd_err",   32'(rd_err), 32'(e_err));
            chk("rnd_data",  rd_data, e_data);
            kb  = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, (kb ? DK : DU) + 8);
            a   = (kb ? 32'h8000_0000 : 32'h0) + 32'(idx) * 32'd4;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(20, 30));
            rd_addr  = a;
            rd_req   = ($urandom_range(0, 3) != 0);
            rd_stall = ($urandom_range(0, 4) == 0);
            if (!rd_stall) begin
                e_valid = rd_req;
                if (rd_req) model_fetch(rd_addr, e_err, e_data);
            end
            step();
        end
        rd_req = 1'b0; rd_stall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_inst_mem_banked
`default_nettype wire
